// File: rtl/pwm_pkg.sv
// Shared types and helpers for the PWM DAC output bank.
package pwm_pkg;

  // Position of the high pulse within each PWM period.
  typedef enum logic {
    ALIGN_LEFT  = 1'b0,
    ALIGN_RIGHT = 1'b1
  } align_e;

  // Working width used by the saturation helper; any IN_WIDTH/WIDTH below this fits.
  localparam int SAT_W = 64;

  // Number of clk cycles in one PWM period for a given counter width.
  function automatic logic [SAT_W-1:0] period_cycles(input int width);
    return SAT_W'(1) << width;
  endfunction

  // Largest duty value, which also gives exactly one low cycle per period.
  function automatic logic [SAT_W-1:0] duty_max(input int width);
    return period_cycles(width) - SAT_W'(1);
  endfunction

  // Clamp a sign-extended sample into 0 .. 2**width-1 instead of wrapping.
  function automatic logic [SAT_W-1:0] sat_duty(input logic signed [SAT_W-1:0] x,
                                                input int width);
    logic [SAT_W-1:0] max_v;
    max_v = duty_max(width);
    if (x < 0) begin
      return '0;
    end else if ($unsigned(x) > max_v) begin
      return max_v;
    end else begin
      return $unsigned(x);
    end
  endfunction

endpackage

// File: rtl/pwm_channel.sv
// One PWM channel: valid/ready intake, saturation, shadow/active duty,
// underrun flag and registered compare output.
module pwm_channel
  import pwm_pkg::*;
#(
  parameter int     WIDTH    = 23,
  parameter int     IN_WIDTH = 32,
  parameter align_e ALIGN    = ALIGN_LEFT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                tick,
  input  logic [WIDTH-1:0]    cnt,
  input  logic                in_valid,
  input  logic [IN_WIDTH-1:0] in_data,
  output logic                in_ready,
  output logic                pwm_out,
  output logic                underrun
);

  logic                    pending_reg;
  logic                    underrun_reg;
  logic                    pwm_reg;
  logic [WIDTH-1:0]        shadow_reg;
  logic [WIDTH-1:0]        active_reg;
  logic [WIDTH-1:0]        sat_val;
  logic [WIDTH-1:0]        duty_eff;
  logic signed [SAT_W-1:0] in_ext;
  logic                    accept;
  logic                    load;
  logic                    pwm_next;

  assign in_ready = ~pending_reg & ~rst;
  assign accept   = in_valid & in_ready;
  assign load     = tick & pending_reg;

  assign in_ext  = {{(SAT_W-IN_WIDTH){in_data[IN_WIDTH-1]}}, in_data};
  assign sat_val = WIDTH'(sat_duty(in_ext, WIDTH));

  // On the tick cycle the compare must already see the duty the new period uses.
  assign duty_eff = load ? shadow_reg : active_reg;

  generate
    if (ALIGN == ALIGN_RIGHT) begin : g_right
      // High for the last D cycles: cnt >= 2**WIDTH - D, done without subtraction.
      assign pwm_next = ({1'b0, cnt} + {1'b0, duty_eff}) >= {1'b1, {WIDTH{1'b0}}};
    end else begin : g_left
      // High for the first D cycles of the period.
      assign pwm_next = cnt < duty_eff;
    end
  endgenerate

  // Shadow/pending intake and hand-over to the active duty at the period boundary.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending_reg <= 1'b0;
      shadow_reg  <= '0;
      active_reg  <= '0;
    end else begin
      if (load) begin
        active_reg  <= shadow_reg;
        pending_reg <= 1'b0;
      end
      if (accept) begin
        shadow_reg  <= sat_val;
        pending_reg <= 1'b1;
      end
    end
  end

  // Sticky flag: a boundary passed with nothing pending.
  always_ff @(posedge clk) begin
    if (rst) begin
      underrun_reg <= 1'b0;
    end else if (tick && !pending_reg) begin
      underrun_reg <= 1'b1;
    end
  end

  // Registered output stage, one cycle behind the compare.
  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_reg <= 1'b0;
    end else begin
      pwm_reg <= pwm_next;
    end
  end

  assign pwm_out  = pwm_reg;
  assign underrun = underrun_reg;

endmodule

// File: rtl/pwm_bank.sv
// Multi-channel PWM DAC bank: shared period counter, sample pacing strobe,
// stimulus address counter and CHANNELS independent PWM channels.
module pwm_bank
  import pwm_pkg::*;
#(
  parameter int CHANNELS   = 2,
  parameter int WIDTH      = 23,
  parameter int IN_WIDTH   = 32,
  parameter int ADDR_WIDTH = 15,
  parameter int ALIGN      = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [CHANNELS-1:0]          in_valid,
  input  logic [CHANNELS*IN_WIDTH-1:0] in_data,
  output logic [CHANNELS-1:0]          in_ready,
  output logic                         sample_tick,
  output logic [ADDR_WIDTH-1:0]        sample_addr,
  output logic [CHANNELS-1:0]          pwm_out,
  output logic [CHANNELS-1:0]          underrun
);

  localparam align_e ALIGN_MODE = (ALIGN != 0) ? ALIGN_RIGHT : ALIGN_LEFT;

  logic [WIDTH-1:0]      cnt_reg;
  logic [ADDR_WIDTH-1:0] addr_reg;
  logic                  tick;

  // The first tick lands on the first cycle after reset releases, since cnt resets to 0.
  assign tick        = (cnt_reg == '0) & ~rst;
  assign sample_tick = tick;
  assign sample_addr = addr_reg;

  // Free-running period counter, wraps naturally at 2**WIDTH.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + WIDTH'(1);
    end
  end

  // Stimulus ROM address advances once per period, wrapping at 2**ADDR_WIDTH.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_reg <= '0;
    end else if (tick) begin
      addr_reg <= addr_reg + ADDR_WIDTH'(1);
    end
  end

  generate
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
      pwm_channel #(
        .WIDTH    (WIDTH),
        .IN_WIDTH (IN_WIDTH),
        .ALIGN    (ALIGN_MODE)
      ) u_ch (
        .clk      (clk),
        .rst      (rst),
        .tick     (tick),
        .cnt      (cnt_reg),
        .in_valid (in_valid[gi]),
        .in_data  (in_data[gi*IN_WIDTH +: IN_WIDTH]),
        .in_ready (in_ready[gi]),
        .pwm_out  (pwm_out[gi]),
        .underrun (underrun[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_pwm_bank.sv
// Directed bench for pwm_bank: a left-aligned and a right-aligned instance
// share the same stimulus. Pattern bit k-1 holds pwm_out on cycle T+k after tick T.
module tb_pwm_bank;

  localparam int CH = 2;
  localparam int W  = 4;
  localparam int IW = 8;
  localparam int AW = 3;

  logic            clk = 1'b0;
  logic            rst;
  logic [CH-1:0]   in_valid;
  logic [CH*IW-1:0] in_data;
  logic [CH-1:0]   ready_l, ready_r, pwm_l, pwm_r, urun_l, urun_r;
  logic            tick_l, tick_r;
  logic [AW-1:0]   addr_l, addr_r;

  int n_assert = 0;
  int n_fail   = 0;
  int pos      = 0;
  logic [31:0] pat_l0, pat_l1, pat_r0, pat_r1;

  always #5 clk = ~clk;

  pwm_bank #(.CHANNELS(CH), .WIDTH(W), .IN_WIDTH(IW), .ADDR_WIDTH(AW), .ALIGN(0)) dut_l (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(ready_l),
    .sample_tick(tick_l), .sample_addr(addr_l), .pwm_out(pwm_l), .underrun(urun_l)
  );

  pwm_bank #(.CHANNELS(CH), .WIDTH(W), .IN_WIDTH(IW), .ADDR_WIDTH(AW), .ALIGN(1)) dut_r (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(ready_r),
    .sample_tick(tick_r), .sample_addr(addr_r), .pwm_out(pwm_r), .underrun(urun_r)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clr;
    pat_l0 = '0; pat_l1 = '0; pat_r0 = '0; pat_r1 = '0;
    pos = 0;
  endtask

  // Step n falling edges, recording the outputs of both instances.
  task automatic capture(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      pat_l0[pos] = pwm_l[0];
      pat_l1[pos] = pwm_l[1];
      pat_r0[pos] = pwm_r[0];
      pat_r1[pos] = pwm_r[1];
      pos++;
    end
  endtask

  initial begin
    rst      = 1'b1;
    in_valid = '0;
    in_data  = '0;
    clr();
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_tick",     32'(tick_l),  32'h0);
    check("rst_ready",    32'(ready_l), 32'h0);
    check("rst_addr",     32'(addr_l),  32'h0);
    check("rst_pwm_l",    32'(pwm_l),   32'h0);
    check("rst_pwm_r",    32'(pwm_r),   32'h0);
    check("rst_underrun", 32'(urun_l),  32'h0);

    // 1: release reset with ch0=5 offered on the first tick cycle (t=0)
    rst = 1'b0;
    in_valid[0] = 1'b1;
    in_data[0 +: IW] = 8'd5;
    #1;
    check("t1_first_tick", 32'(tick_l),  32'h1);
    check("t1_ready",      32'(ready_l), 32'h3);
    clr();
    capture(1);                                       // t=1
    in_valid[0] = 1'b0;
    check("t1_underrun",   32'(urun_l),  32'h3);
    check("t1_ready_busy", 32'(ready_l), 32'h2);
    check("t1_addr",       32'(addr_l),  32'h1);
    capture(15);                                      // t=16
    check("t1_tick16",     32'(tick_l),  32'h1);
    check("t1_p1_ch0",     pat_l0,       32'h0);
    clr();
    capture(16);                                      // t=32
    check("t1_tick32",     32'(tick_l),  32'h1);
    check("t1_p2_ch0",     pat_l0,       32'h001F);
    check("t1_p2_ch1",     pat_l1,       32'h0);

    // 2: saturation; ch0=-3 -> 0, ch1=16 -> 15
    capture(1);                                       // t=33
    in_valid = 2'b11;
    in_data  = {8'd16, 8'hFD};
    capture(1);                                       // t=34
    in_valid = 2'b00;
    check("t2_ready_busy", 32'(ready_l), 32'h0);
    capture(14);                                      // t=48
    clr();
    capture(16);                                      // t=64
    check("t2_neg_ch0",    pat_l0,       32'h0);
    check("t2_big_ch1_l",  pat_l1,       32'h7FFF);
    check("t2_big_ch1_r",  pat_r1,       32'hFFFE);
    check("t2_neg_ch0_r",  pat_r0,       32'h0);
    // ch0=127 -> 15 high, ch1=0 -> 0 high
    capture(1);                                       // t=65
    in_valid = 2'b11;
    in_data  = {8'd0, 8'd127};
    capture(1);                                       // t=66
    in_valid = 2'b00;
    capture(14);                                      // t=80
    clr();
    capture(16);                                      // t=96
    check("t2_max_ch0_l",  pat_l0,       32'h7FFF);
    check("t2_max_ch0_r",  pat_r0,       32'hFFFE);
    check("t2_zero_ch1",   pat_l1,       32'h0);

    // 3: backpressure; ch0 holds valid with 3 then 9, ch1 sends 6 alongside
    capture(1);                                       // t=97
    in_valid = 2'b11;
    in_data  = {8'd6, 8'd3};
    check("t3_ready_pre",  32'(ready_l[0]), 32'h1);
    capture(1);                                       // t=98
    in_valid[1] = 1'b0;
    in_data[0 +: IW] = 8'd9;
    check("t3_ready_drop", 32'(ready_l[0]), 32'h0);
    capture(14);                                      // t=112
    check("t3_ready_tick", 32'(ready_l[0]), 32'h0);
    clr();
    capture(1);                                       // t=113
    check("t3_ready_rise", 32'(ready_l[0]), 32'h1);
    capture(1);                                       // t=114
    in_valid[0] = 1'b0;
    check("t3_ready_drop2", 32'(ready_l[0]), 32'h0);
    capture(14);                                      // t=128
    check("t3_p_3",        pat_l0,       32'h0007);
    check("t3_ch1_6",      pat_l1,       32'h003F);
    clr();
    capture(16);                                      // t=144
    check("t3_p_9",        pat_l0,       32'h01FF);
    check("t3_ch1_held",   pat_l1,       32'h003F);

    // 4: value 7 accepted on the tick cycle itself
    check("t4_tick",       32'(tick_l),  32'h1);
    in_valid[0] = 1'b1;
    in_data[0 +: IW] = 8'd7;
    clr();
    capture(1);                                       // t=145
    in_valid[0] = 1'b0;
    check("t4_ready_busy", 32'(ready_l[0]), 32'h0);
    capture(15);                                      // t=160
    check("t4_old_duty",   pat_l0,       32'h01FF);
    clr();
    capture(16);                                      // t=176
    check("t4_new_duty",   pat_l0,       32'h007F);

    // 5: D=4; right-aligned ends on the tick, left-aligned starts after it
    capture(1);                                       // t=177
    in_valid[0] = 1'b1;
    in_data[0 +: IW] = 8'd4;
    capture(1);                                       // t=178
    in_valid[0] = 1'b0;
    capture(14);                                      // t=192
    clr();
    capture(16);                                      // t=208, tick #13
    check("t5_left_4",     pat_l0,       32'h000F);
    check("t5_right_4",    pat_r0,       32'hF000);
    check("t5_addr_t13",   32'(addr_l),  32'h5);
    for (int i = 0; i < 9; i++) begin
      clr();
      capture(16);                                    // tick #14+i
      check("t5_period_tick", 32'(tick_l), 32'h1);
      check("t5_right_loop",  pat_r0,      32'hF000);
      check("t5_addr_seq",    32'(addr_l), 32'((14 + i) % 8));
    end                                               // t=352

    // 6: reset for one cycle at cnt=9 while outputs are high, with a sample pending
    capture(1);                                       // t=353
    in_valid[0] = 1'b1;
    in_data[0 +: IW] = 8'd12;
    capture(1);                                       // t=354
    in_valid[0] = 1'b0;
    capture(14);                                      // t=368
    capture(1);                                       // t=369
    in_valid[0] = 1'b1;
    in_data[0 +: IW] = 8'd2;
    capture(1);                                       // t=370
    in_valid[0] = 1'b0;
    check("t6_pending",    32'(ready_l[0]), 32'h0);
    capture(7);                                       // t=377, cnt=9
    check("t6_high_l",     32'(pwm_l[0]), 32'h1);
    check("t6_high_r",     32'(pwm_r[0]), 32'h1);
    rst = 1'b1;
    capture(1);                                       // t=378
    check("t6_pwm_l",      32'(pwm_l),   32'h0);
    check("t6_pwm_r",      32'(pwm_r),   32'h0);
    check("t6_ready",      32'(ready_l), 32'h0);
    check("t6_addr",       32'(addr_l),  32'h0);
    check("t6_underrun",   32'(urun_l),  32'h0);
    check("t6_tick_rst",   32'(tick_l),  32'h0);
    rst = 1'b0;
    #1;
    check("t6_tick_rel",   32'(tick_l),  32'h1);
    check("t6_discard",    32'(ready_l), 32'h3);
    clr();
    capture(1);                                       // 1 cycle after new first tick
    check("t6_underrun2",  32'(urun_l),  32'h3);
    check("t6_addr1",      32'(addr_l),  32'h1);
    capture(15);
    check("t6_tick_again", 32'(tick_l),  32'h1);
    check("t6_zero_l",     pat_l0,       32'h0);
    check("t6_zero_r",     pat_r0,       32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
